// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC, issues I-cache reads and buffers {instr, pc} in a DEPTH-entry FIFO.
// Define FETCH_BTFN_PREDICT_EN to add static backward-taken branch / jump prediction.
module fetch_queue #(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] PC_INIT = '0,
    parameter int unsigned      DEPTH   = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    output logic                       imemREN,
    output logic [WIDTH-1:0]           imemaddr,
    input  logic                       ihit,
    input  logic [WIDTH-1:0]           imemload,
    input  logic                       redirect,
    input  logic [WIDTH-1:0]           redirect_pc,
    input  logic                       halt,
    input  logic                       deq,
    output logic                       inst_valid,
    output logic [WIDTH-1:0]           inst,
    output logic [WIDTH-1:0]           inst_pc,
    output logic [WIDTH-1:0]           inst_npc,
`ifdef FETCH_BTFN_PREDICT_EN
    output logic                       inst_pred_taken,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned      PW   = $clog2(DEPTH);
    localparam int unsigned      CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]    FULL = CW'(DEPTH);
    localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

    logic [WIDTH-1:0] r_fpc;
    logic [WIDTH-1:0] r_instr [DEPTH];
    logic [WIDTH-1:0] r_pc    [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             r_halted;

    logic             w_enq;
    logic             w_deq;
    logic [WIDTH-1:0] w_seq_pc;
    logic [WIDTH-1:0] w_next_fpc;

    assign imemREN  = !RST && !r_halted && (r_count < FULL);
    assign imemaddr = r_fpc;
    // Redirect squashes both the returning word and any dequeue in the same cycle.
    assign w_enq    = imemREN && ihit && !redirect;
    assign w_deq    = deq && (r_count != '0) && !redirect;
    assign w_seq_pc = r_fpc + FOUR;

`ifdef FETCH_BTFN_PREDICT_EN
    logic w_pred;
    logic r_pred [DEPTH];

    always_comb begin
        w_pred     = 1'b0;
        w_next_fpc = w_seq_pc;
        case (imemload[31:26])
            6'b000100, 6'b000101: begin
                // Backward branches (negative offset) are predicted taken.
                if (imemload[15]) begin
                    w_pred     = 1'b1;
                    w_next_fpc = w_seq_pc + {{(WIDTH-18){imemload[15]}}, imemload[15:0], 2'b00};
                end
            end
            6'b000010, 6'b000011: begin
                w_pred     = 1'b1;
                w_next_fpc = {w_seq_pc[31:28], imemload[25:0], 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (w_enq) begin
            r_pred[r_wr_ptr] <= w_pred;
        end
    end

    assign inst_pred_taken = r_pred[r_rd_ptr];
`else
    assign w_next_fpc = w_seq_pc;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_fpc    <= PC_INIT;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_halted <= 1'b0;
        end else begin
            if (halt) begin
                r_halted <= 1'b1;
            end
            if (redirect) begin
                r_fpc    <= redirect_pc;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_enq) begin
                    r_fpc    <= w_next_fpc;
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_deq) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                if (w_enq && !w_deq) begin
                    r_count <= r_count + CW'(1);
                end else if (!w_enq && w_deq) begin
                    r_count <= r_count - CW'(1);
                end
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge CLK) begin
        if (w_enq) begin
            r_instr[r_wr_ptr] <= imemload;
            r_pc[r_wr_ptr]    <= r_fpc;
        end
    end

    assign inst_valid = (r_count != '0);
    assign inst       = r_instr[r_rd_ptr];
    assign inst_pc    = r_pc[r_rd_ptr];
    assign inst_npc   = r_pc[r_rd_ptr] + FOUR;
    assign count      = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed stimulus plus a scoreboard/monitor that checks every cycle.
module tb_fetch_queue;
    localparam int unsigned W = 32;
    localparam int unsigned D = 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         ihit = 1'b0;
    logic         redirect = 1'b0;
    logic         halt = 1'b0;
    logic         deq = 1'b0;
    logic [W-1:0] imemload = '0;
    logic [W-1:0] redirect_pc = '0;
    logic         imemREN;
    logic         inst_valid;
    logic [W-1:0] imemaddr;
    logic [W-1:0] inst;
    logic [W-1:0] inst_pc;
    logic [W-1:0] inst_npc;
    logic [2:0]   count;
`ifdef FETCH_BTFN_PREDICT_EN
    logic         inst_pred_taken;
`endif

    fetch_queue #(
        .WIDTH   (W),
        .PC_INIT ('0),
        .DEPTH   (D)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .imemREN     (imemREN),
        .imemaddr    (imemaddr),
        .ihit        (ihit),
        .imemload    (imemload),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .deq         (deq),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_npc    (inst_npc),
`ifdef FETCH_BTFN_PREDICT_EN
        .inst_pred_taken (inst_pred_taken),
`endif
        .count       (count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [W-1:0] m_next(input logic [W-1:0] pc, input logic [W-1:0] w);
        logic [W-1:0] s;
        s = pc + 32'd4;
`ifdef FETCH_BTFN_PREDICT_EN
        if ((w[31:26] == 6'h04 || w[31:26] == 6'h05) && w[15])
            return s + {{14{w[15]}}, w[15:0], 2'b00};
        if (w[31:26] == 6'h02 || w[31:26] == 6'h03)
            return {s[31:28], w[25:0], 2'b00};
`endif
        return s;
    endfunction

    typedef struct packed {
        logic [W-1:0] instr;
        logic [W-1:0] pc;
    } ent_t;

    ent_t         sb[$];
    logic [W-1:0] m_fpc = '0;
    int           m_cnt = 0;
    bit           m_halt = 1'b0;
    bit           m_ren;

    // Monitor: compare outputs against the reference state, then advance it for the next edge.
    initial begin
        @(posedge CLK);
        forever begin
            @(negedge CLK);
            m_ren = !RST && !m_halt && (m_cnt < D);
            check("imemREN", W'(imemREN), W'(m_ren));
            check("imemaddr", imemaddr, m_fpc);
            check("count", W'(count), W'(m_cnt));
            check("inst_valid", W'(inst_valid), W'(m_cnt != 0));
            if (m_cnt > 0 && sb.size() > 0) begin
                check("head_inst", inst, sb[0].instr);
                check("head_pc", inst_pc, sb[0].pc);
                check("head_npc", inst_npc, sb[0].pc + 32'd4);
            end
            if (RST) begin
                m_fpc = '0; m_cnt = 0; m_halt = 1'b0; sb.delete();
            end else begin
                if (redirect) begin
                    m_fpc = redirect_pc; m_cnt = 0; sb.delete();
                end else begin
                    if (deq && m_cnt > 0) begin
                        sb.delete(0);
                        m_cnt--;
                    end
                    if (ihit && m_ren) begin
                        sb.push_back('{instr: imemload, pc: m_fpc});
                        m_fpc = m_next(m_fpc, imemload);
                        m_cnt++;
                    end
                end
                if (halt) m_halt = 1'b1;
            end
        end
    end

    initial begin
        repeat (2) cyc();
        check("rst_count", W'(count), 0);
        check("rst_ren", W'(imemREN), 0);
        check("rst_valid", W'(inst_valid), 0);
        RST = 1'b0;
        #1;
        check("rel_ren", W'(imemREN), 1);
        check("rel_addr", imemaddr, 32'h0);

        // Fill to DEPTH with no dequeue.
        for (int i = 0; i < 4; i++) begin
            ihit = 1'b1;
            imemload = 32'hA + i;
            cyc();
        end
        check("full_count", W'(count), 4);
        check("full_ren", W'(imemREN), 0);
        check("full_head", inst, 32'hA);
        check("full_pc", inst_pc, 32'h0);
        check("full_addr", imemaddr, 32'h10);
        imemload = 32'hEE;
        cyc();
        check("full_ignore", W'(count), 4);

        // One dequeue reopens the request.
        ihit = 1'b0;
        deq = 1'b1;
        cyc();
        check("deq1_pc", inst_pc, 32'h4);
        check("deq1_count", W'(count), 3);
        check("deq1_ren", W'(imemREN), 1);
        check("deq1_addr", imemaddr, 32'h10);
        cyc();
        cyc();
        check("drain_pc", inst_pc, 32'hC);

        // Steady enqueue + dequeue, pointers wrap several times.
        ihit = 1'b1;
        for (int i = 0; i < 20; i++) begin
            imemload = 32'h100 + i;
            cyc();
        end
        check("stream_count", W'(count), 1);
        check("stream_pc", inst_pc, 32'h5C);
        check("stream_inst", inst, 32'h113);
        check("stream_addr", imemaddr, 32'h60);

        // Redirect flush with count=3 and a same-cycle ihit/deq.
        deq = 1'b0;
        for (int i = 0; i < 2; i++) begin
            imemload = 32'h200 + i;
            cyc();
        end
        check("pre_rdr_count", W'(count), 3);
        redirect = 1'b1;
        redirect_pc = 32'h400;
        imemload = 32'hDEAD;
        deq = 1'b1;
        cyc();
        redirect = 1'b0;
        deq = 1'b0;
        ihit = 1'b0;
        check("rdr_count", W'(count), 0);
        check("rdr_valid", W'(inst_valid), 0);
        check("rdr_addr", imemaddr, 32'h400);
        check("rdr_ren", W'(imemREN), 1);

        // Halt with two entries, then drain.
        ihit = 1'b1;
        for (int i = 0; i < 2; i++) begin
            imemload = 32'h300 + i;
            cyc();
        end
        ihit = 1'b0;
        halt = 1'b1;
        cyc();
        halt = 1'b0;
        check("halt_ren", W'(imemREN), 0);
        check("halt_count", W'(count), 2);
        check("halt_addr", imemaddr, 32'h408);
        ihit = 1'b1;
        deq = 1'b1;
        cyc();
        check("halt_deq1_pc", inst_pc, 32'h404);
        cyc();
        deq = 1'b0;
        check("halt_empty", W'(count), 0);
        check("halt_ren2", W'(imemREN), 0);
        redirect = 1'b1;
        redirect_pc = 32'h800;
        cyc();
        redirect = 1'b0;
        ihit = 1'b0;
        check("halt_rdr_addr", imemaddr, 32'h800);
        check("halt_rdr_ren", W'(imemREN), 0);
        RST = 1'b1;
        cyc();
        check("rst2_ren", W'(imemREN), 0);
        RST = 1'b0;
        #1;
        check("rst2_ren_rel", W'(imemREN), 1);
        check("rst2_addr", imemaddr, 32'h0);

        // Backward BEQ at 0x100.
        redirect = 1'b1;
        redirect_pc = 32'h100;
        cyc();
        redirect = 1'b0;
        ihit = 1'b1;
        imemload = 32'h1000FFFE;
        cyc();
        ihit = 1'b0;
        check("beq_inst", inst, 32'h1000FFFE);
        check("beq_pc", inst_pc, 32'h100);
`ifdef FETCH_BTFN_PREDICT_EN
        check("beq_addr", imemaddr, 32'hFC);
        check("beq_pred", W'(inst_pred_taken), 1);
`else
        check("beq_addr", imemaddr, 32'h104);
`endif
        deq = 1'b1;
        cyc();
        deq = 1'b0;
        cyc();
        check("end_empty", W'(inst_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
